// File: rtl/ssd_scan.sv
// Multiplexed seven-segment scanner: double-buffered hex data, leading-zero
// blanking, per-digit decimal points and PWM brightness, all outputs registered.
module ssd_scan #(
  parameter int unsigned NDIG          = 8,
  parameter int unsigned CLK_DIV       = 16,
  parameter bit          ANODE_ACT_LOW = 1'b1,
  parameter bit          SEG_ACT_LOW   = 1'b1
) (
  input  logic                                         clk,
  input  logic                                         rst_i,
  input  logic                                         enable_i,
  input  logic                                         load_i,
  input  logic [4*NDIG-1:0]                            data_i,
  input  logic [NDIG-1:0]                              dp_i,
  input  logic                                         blank_lz_i,
  input  logic [3:0]                                   bright_i,
  output logic [NDIG-1:0]                              anode,
  output logic [6:0]                                   display,
  output logic                                         dp_o,
  output logic [((NDIG > 1) ? $clog2(NDIG) : 1)-1:0]   digit_idx_o,
  output logic                                         frame_o
);

  localparam int unsigned IW  = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned DW  = $clog2(CLK_DIV);
  localparam int unsigned BW  = $clog2(CLK_DIV) + 5;
  localparam int unsigned DAW = 4 * NDIG;

  localparam logic [NDIG-1:0] ANODE_OFF = ANODE_ACT_LOW ? {NDIG{1'b1}} : {NDIG{1'b0}};
  localparam logic [6:0]      SEG_OFF   = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic            DP_OFF    = SEG_ACT_LOW;

  typedef enum logic {ST_IDLE, ST_SCAN} state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     div_cnt_q, div_cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DAW-1:0]    pend_data_q, pend_data_d, act_data_q, act_data_d;
  logic [NDIG-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic              pend_flag_q, pend_flag_d;
  logic [NDIG-1:0]   anode_q, anode_d;
  logic [6:0]        display_q, display_d;
  logic              dp_q, dp_d;
  logic [IW-1:0]     digit_idx_q, digit_idx_d;
  logic              frame_q, frame_d;

  logic              wrap_c, xfer_c;
  logic [NDIG-1:0]   blank_c, onehot_c;
  logic              zero_run_c, cur_blank_c, cur_dp_c, lit_c;
  logic [3:0]        cur_nib_c;
  logic [BW-1:0]     duty_pos_c, duty_lim_c;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;  4'h1: seg = 7'h06;  4'h2: seg = 7'h5B;  4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;  4'h5: seg = 7'h6D;  4'h6: seg = 7'h7D;  4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;  4'h9: seg = 7'h6F;  4'hA: seg = 7'h77;  4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;  4'hD: seg = 7'h5E;  4'hE: seg = 7'h79;  default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Scan sequencing and double-buffer transfer
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    idx_d       = idx_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    pend_flag_d = pend_flag_q;
    wrap_c      = 1'b0;
    xfer_c      = 1'b0;

    if (!enable_i) begin
      state_d   = ST_IDLE;
      div_cnt_d = '0;
      idx_d     = '0;
    end else begin
      state_d = ST_SCAN;
      if (state_q == ST_SCAN) begin
        if (div_cnt_q == DW'(CLK_DIV - 1)) begin
          div_cnt_d = '0;
          if (idx_q == IW'(NDIG - 1)) begin
            idx_d  = '0;
            wrap_c = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
    end

    // Transfer sees the pre-load pending value; a coincident load re-arms the flag
    xfer_c = pend_flag_q && (wrap_c || (state_q == ST_IDLE));
    if (xfer_c) begin
      act_data_d  = pend_data_q;
      act_dp_d    = pend_dp_q;
      pend_flag_d = 1'b0;
    end
    if (load_i) begin
      pend_data_d = data_i;
      pend_dp_d   = dp_i;
      pend_flag_d = 1'b1;
    end
  end

  // Output decode from current scan position and active buffer
  always_comb begin
    blank_c     = '0;
    onehot_c    = '0;
    zero_run_c  = 1'b1;
    cur_blank_c = 1'b0;
    cur_dp_c    = 1'b0;
    cur_nib_c   = 4'h0;

    for (int k = int'(NDIG) - 1; k >= 0; k--) begin
      zero_run_c = zero_run_c && (act_data_q[4*k +: 4] == 4'h0);
      blank_c[k] = blank_lz_i && (k != 0) && zero_run_c;
    end

    for (int unsigned k = 0; k < NDIG; k++) begin
      if (idx_q == IW'(k)) begin
        onehot_c[k] = 1'b1;
        cur_nib_c   = act_data_q[4*k +: 4];
        cur_dp_c    = act_dp_q[k];
        cur_blank_c = blank_c[k];
      end
    end

    duty_pos_c = BW'(div_cnt_q) * BW'(16);
    duty_lim_c = (BW'(bright_i) + BW'(1)) * BW'(CLK_DIV);
    lit_c = (state_q == ST_SCAN) && enable_i && !cur_blank_c && (duty_pos_c < duty_lim_c);

    anode_d     = ANODE_OFF;
    display_d   = SEG_OFF;
    dp_d        = DP_OFF;
    digit_idx_d = idx_q;
    frame_d     = wrap_c;
    if (lit_c) begin
      anode_d   = onehot_c ^ {NDIG{ANODE_ACT_LOW}};
      display_d = seg_decode(cur_nib_c) ^ {7{SEG_ACT_LOW}};
      dp_d      = cur_dp_c ^ SEG_ACT_LOW;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      div_cnt_q   <= '0;
      idx_q       <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      pend_flag_q <= 1'b0;
      anode_q     <= ANODE_OFF;
      display_q   <= SEG_OFF;
      dp_q        <= DP_OFF;
      digit_idx_q <= '0;
      frame_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      idx_q       <= idx_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      pend_flag_q <= pend_flag_d;
      anode_q     <= anode_d;
      display_q   <= display_d;
      dp_q        <= dp_d;
      digit_idx_q <= digit_idx_d;
      frame_q     <= frame_d;
    end
  end

  assign anode       = anode_q;
  assign display     = display_q;
  assign dp_o        = dp_q;
  assign digit_idx_o = digit_idx_q;
  assign frame_o     = frame_q;

endmodule

// File: tb/tb_ssd_scan.sv
// Directed bench for ssd_scan with NDIG=4, CLK_DIV=16, active-low outputs.
module tb_ssd_scan;

  localparam int unsigned NDIG    = 4;
  localparam int unsigned CLK_DIV = 16;

  logic        clk = 1'b0;
  logic        rst_i, enable_i, load_i, blank_lz_i;
  logic [15:0] data_i;
  logic [3:0]  dp_i, bright_i;
  logic [3:0]  anode;
  logic [6:0]  display;
  logic        dp_o, frame_o;
  logic [1:0]  digit_idx_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ssd_scan #(.NDIG(NDIG), .CLK_DIV(CLK_DIV), .ANODE_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)) dut (
    .clk(clk), .rst_i(rst_i), .enable_i(enable_i), .load_i(load_i), .data_i(data_i),
    .dp_i(dp_i), .blank_lz_i(blank_lz_i), .bright_i(bright_i), .anode(anode),
    .display(display), .dp_o(dp_o), .digit_idx_o(digit_idx_o), .frame_o(frame_o)
  );

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        blz;
    logic [3:0]  br;
    int          slot;
    int          cyc;
    logic [3:0]  exp_anode;
    logic [6:0]  exp_disp;
    logic        exp_dp;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_frame(input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_o) begin
        found = 1'b1;
        break;
      end
    end
    chk(name, 32'(found), 32'd1);
  endtask

  task automatic setup(input logic [15:0] data, input logic [3:0] dp, input logic blz,
                       input logic [3:0] br);
    @(negedge clk);
    rst_i = 1'b0; enable_i = 1'b0; load_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1; data_i = data; dp_i = dp; blank_lz_i = blz; bright_i = br;
    load_i = 1'b1; enable_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    wait_frame("setup_frame");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_i = 1'b0; enable_i = 1'b0; load_i = 1'b0; blank_lz_i = 1'b0;
    data_i = '0; dp_i = '0; bright_i = 4'hF;

    vecs[0]  = '{16'h12AF, 4'h0, 1'b0, 4'hF, 0, 0,  4'b1110, 7'h0E, 1'b1};
    vecs[1]  = '{16'h12AF, 4'h0, 1'b0, 4'hF, 1, 5,  4'b1101, 7'h08, 1'b1};
    vecs[2]  = '{16'h12AF, 4'h0, 1'b0, 4'hF, 2, 15, 4'b1011, 7'h24, 1'b1};
    vecs[3]  = '{16'h12AF, 4'h0, 1'b0, 4'hF, 3, 8,  4'b0111, 7'h79, 1'b1};
    vecs[4]  = '{16'h0005, 4'h0, 1'b1, 4'hF, 0, 3,  4'b1110, 7'h12, 1'b1};
    vecs[5]  = '{16'h0005, 4'h0, 1'b1, 4'hF, 1, 0,  4'b1111, 7'h7F, 1'b1};
    vecs[6]  = '{16'h0005, 4'h0, 1'b1, 4'hF, 3, 0,  4'b1111, 7'h7F, 1'b1};
    vecs[7]  = '{16'h0000, 4'h0, 1'b1, 4'hF, 0, 0,  4'b1110, 7'h40, 1'b1};
    vecs[8]  = '{16'h0000, 4'h0, 1'b1, 4'hF, 2, 7,  4'b1111, 7'h7F, 1'b1};
    vecs[9]  = '{16'h0000, 4'h0, 1'b0, 4'hF, 3, 0,  4'b0111, 7'h40, 1'b1};
    vecs[10] = '{16'h12AF, 4'h0, 1'b0, 4'h3, 1, 3,  4'b1101, 7'h08, 1'b1};
    vecs[11] = '{16'h12AF, 4'h0, 1'b0, 4'h3, 1, 4,  4'b1111, 7'h7F, 1'b1};
    vecs[12] = '{16'h12AF, 4'h0, 1'b0, 4'h3, 1, 15, 4'b1111, 7'h7F, 1'b1};
    vecs[13] = '{16'h12AF, 4'h0, 1'b0, 4'h0, 2, 0,  4'b1011, 7'h24, 1'b1};
    vecs[14] = '{16'h12AF, 4'h0, 1'b0, 4'h0, 2, 1,  4'b1111, 7'h7F, 1'b1};
    vecs[15] = '{16'h1234, 4'h4, 1'b0, 4'hF, 2, 0,  4'b1011, 7'h24, 1'b0};
    vecs[16] = '{16'h1234, 4'h4, 1'b0, 4'hF, 1, 0,  4'b1101, 7'h30, 1'b1};
    vecs[17] = '{16'h0012, 4'h4, 1'b1, 4'hF, 2, 0,  4'b1111, 7'h7F, 1'b1};
    vecs[18] = '{16'h0012, 4'h4, 1'b0, 4'hF, 2, 0,  4'b1011, 7'h40, 1'b0};
    vecs[19] = '{16'h0012, 4'h4, 1'b1, 4'hF, 0, 0,  4'b1110, 7'h24, 1'b1};

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_anode", 32'(anode), 32'hF);
    chk("rst_display", 32'(display), 32'h7F);
    chk("rst_dp", 32'(dp_o), 32'h1);
    chk("rst_idx", 32'(digit_idx_o), 32'h0);
    chk("rst_frame", 32'(frame_o), 32'h0);

    // First frame shows zeros, then frame period and pulse width
    rst_i = 1'b1; data_i = 16'h12AF; load_i = 1'b1; enable_i = 1'b1; bright_i = 4'hF;
    @(negedge clk);
    load_i = 1'b0;
    @(negedge clk);
    chk("first_frame_anode", 32'(anode), 32'hE);
    chk("first_frame_display", 32'(display), 32'h40);
    wait_frame("first_wrap");
    @(negedge clk);
    chk("frame_width", 32'(frame_o), 32'h0);
    n = 1;
    while (!frame_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("frame_period", 32'(n), 32'd64);

    // Table-driven slot checks
    for (int i = 0; i < 20; i++) begin
      setup(vecs[i].data, vecs[i].dp, vecs[i].blz, vecs[i].br);
      step(1 + 16 * vecs[i].slot + vecs[i].cyc);
      chk($sformatf("vec%0d_anode", i), 32'(anode), 32'(vecs[i].exp_anode));
      chk($sformatf("vec%0d_display", i), 32'(display), 32'(vecs[i].exp_disp));
      chk($sformatf("vec%0d_dp", i), 32'(dp_o), 32'(vecs[i].exp_dp));
      chk($sformatf("vec%0d_idx", i), 32'(digit_idx_o), 32'(vecs[i].slot));
    end

    // Tear-free load mid-frame
    setup(16'h2222, 4'h0, 1'b0, 4'hF);
    step(33);
    load_i = 1'b1; data_i = 16'h1111;
    @(negedge clk);
    load_i = 1'b0;
    chk("tear_d2_display", 32'(display), 32'h24);
    chk("tear_d2_anode", 32'(anode), 32'hB);
    step(16);
    chk("tear_d3_display", 32'(display), 32'h24);
    chk("tear_d3_anode", 32'(anode), 32'h7);
    wait_frame("tear_wrap");
    step(1);
    chk("tear_next_d0", 32'(display), 32'h79);
    step(48);
    chk("tear_next_d3", 32'(display), 32'h79);

    // Load coincident with the wrap edge lands one frame later
    wait_frame("wrapload_sync");
    load_i = 1'b1; data_i = 16'h4444;
    @(negedge clk);
    load_i = 1'b0;
    repeat (62) @(negedge clk);
    load_i = 1'b1; data_i = 16'h3333;
    @(negedge clk);
    load_i = 1'b0;
    chk("wrapload_pulse", 32'(frame_o), 32'h1);
    step(1);
    chk("wrapload_frame1", 32'(display), 32'h19);
    wait_frame("wrapload_wrap2");
    step(1);
    chk("wrapload_frame2", 32'(display), 32'h30);

    // Enable drop mid-frame and restart at digit 0
    setup(16'h12AF, 4'h0, 1'b0, 4'hF);
    step(33);
    chk("en_pre_idx", 32'(digit_idx_o), 32'h2);
    enable_i = 1'b0;
    @(negedge clk);
    chk("en_off_anode", 32'(anode), 32'hF);
    chk("en_off_display", 32'(display), 32'h7F);
    @(negedge clk);
    chk("en_off_idx", 32'(digit_idx_o), 32'h0);
    enable_i = 1'b1;
    @(negedge clk);
    chk("en_on_first", 32'(anode), 32'hF);
    @(negedge clk);
    chk("en_on_anode", 32'(anode), 32'hE);
    chk("en_on_idx", 32'(digit_idx_o), 32'h0);
    chk("en_on_display", 32'(display), 32'h0E);

    // Reset mid-frame clears outputs and buffers
    step(16);
    rst_i = 1'b0;
    @(negedge clk);
    chk("mrst_anode", 32'(anode), 32'hF);
    chk("mrst_display", 32'(display), 32'h7F);
    chk("mrst_dp", 32'(dp_o), 32'h1);
    chk("mrst_idx", 32'(digit_idx_o), 32'h0);
    chk("mrst_frame", 32'(frame_o), 32'h0);
    rst_i = 1'b1;
    wait_frame("mrst_wrap");
    step(49);
    chk("mrst_cleared_display", 32'(display), 32'h40);
    chk("mrst_cleared_anode", 32'(anode), 32'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
